moggysoc_mem_arbiter: RTL

Round-robin arbiter that shares one memory/peripheral slave port between `NUM_MASTERS` requesters, such as CPU instruction fetch, CPU load/store and a DMA engine. It sits between the masters and the SoC's shared SRAM/bus port inside `moggysoc_top`. It sequences one transaction at a time: arbitrate, issue, wait for response, route the response back. An optional watchdog converts a hung slave into an error response.

---
 rtl/moggysoc_pkg.sv | 17 +
 rtl/moggysoc_rr_picker.sv | 36 +++
 rtl/moggysoc_mem_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/moggysoc_pkg.sv
// moggysoc_pkg
//   Shared definitions for the moggysoc memory arbiter: the arbiter state
//   encoding and the default address/data widths.
//   Configuration macro MOGGYSOC_ARB_TIMEOUT_EN is consumed by
//   moggysoc_mem_arbiter, not by this package.
package moggysoc_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/moggysoc_rr_picker.sv
// moggysoc_rr_picker
//   Combinational round-robin winner selection. Scans the request vector
//   starting at i_ptr and wrapping modulo N; the first set bit wins.
// Ports:
//   i_req  [N-1:0]     request vector
//   i_ptr  [IDX_W-1:0] search start index (0..N-1)
//   o_idx  [IDX_W-1:0] winning index (0 when o_any is low)
//   o_any              at least one request is set
module moggysoc_rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int w_cand;

  // Walk the candidates from the farthest to the nearest so that the last
  // hit written is the one closest to i_ptr; no "found" flag is needed.
  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = (int'(i_ptr) + k) % N;
      if ((i_req & (N'(1) << w_cand)) != '0) begin
        o_idx = IDX_W'(w_cand);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/moggysoc_mem_arbiter.sv
// moggysoc_mem_arbiter
//   Round-robin arbiter sharing one slave port between NUM_MASTERS
//   requesters. One transaction at a time: IDLE (arbitrate) -> ISSUE
//   (present request to slave) -> WAIT (route the response to the owner).
//   Define MOGGYSOC_ARB_TIMEOUT_EN to build a watchdog that turns a slave
//   silent for TIMEOUT WAIT cycles into an error response.
// Ports:
//   sys_clk, rst_n               clock, asynchronous active-low reset
//   m_req_valid/ready/we         per-master request handshake and write flag
//   m_req_addr/wdata/wstrb       packed per-master request fields
//   m_rsp_valid                  one-hot response valid (owner only)
//   m_rsp_rdata, m_rsp_err       broadcast read data and error flag
//   s_req_valid/ready            slave request handshake
//   s_req_addr/we/wdata/wstrb    request fields muxed from the owner
//   s_rsp_valid, s_rsp_rdata     slave response
module moggysoc_mem_arbiter
  import moggysoc_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int DATA_W      = ARB_DATA_W,
  parameter int TIMEOUT     = 255
) (
  input  logic                            sys_clk,
  input  logic                            rst_n,
  input  logic [NUM_MASTERS-1:0]          m_req_valid,
  output logic [NUM_MASTERS-1:0]          m_req_ready,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_req_addr,
  input  logic [NUM_MASTERS-1:0]          m_req_we,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_req_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_req_wstrb,
  output logic [NUM_MASTERS-1:0]          m_rsp_valid,
  output logic [DATA_W-1:0]               m_rsp_rdata,
  output logic                            m_rsp_err,
  output logic                            s_req_valid,
  input  logic                            s_req_ready,
  output logic [ADDR_W-1:0]               s_req_addr,
  output logic                            s_req_we,
  output logic [DATA_W-1:0]               s_req_wdata,
  output logic [DATA_W/8-1:0]             s_req_wstrb,
  input  logic                            s_rsp_valid,
  input  logic [DATA_W-1:0]               s_rsp_rdata
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int STB_W = DATA_W / 8;

  arb_state_e       r_state, w_state_next;
  logic [IDX_W-1:0] r_owner, w_owner_next;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_next;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic [IDX_W-1:0] w_owner_inc;
  logic             w_timeout;
  logic             w_rsp_fire;
  logic             w_issue;

  logic [ADDR_W-1:0] w_addr  [NUM_MASTERS];
  logic [DATA_W-1:0] w_wdata [NUM_MASTERS];
  logic [STB_W-1:0]  w_wstrb [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] w_sel;

  moggysoc_rr_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req (m_req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Unpack per-master fields and build the owner-qualified handshakes.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
    assign w_addr[gi]      = m_req_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata[gi]     = m_req_wdata[gi*DATA_W +: DATA_W];
    assign w_wstrb[gi]     = m_req_wstrb[gi*STB_W +: STB_W];
    assign w_sel[gi]       = (r_owner == IDX_W'(gi));
    assign m_req_ready[gi] = w_issue & s_req_ready & w_sel[gi];
    assign m_rsp_valid[gi] = w_rsp_fire & w_sel[gi];
  end

  // Masters hold their fields while waiting for ready, so the slave side
  // is a plain mux on the owner with no request copy.
  assign w_issue     = (r_state == ISSUE);
  assign s_req_valid = w_issue;
  assign s_req_addr  = w_addr[r_owner];
  assign s_req_we    = m_req_we[r_owner];
  assign s_req_wdata = w_wdata[r_owner];
  assign s_req_wstrb = w_wstrb[r_owner];

  // A slave response outside WAIT is simply ignored.
  assign w_rsp_fire  = (r_state == WAIT) & (s_rsp_valid | w_timeout);
  assign w_owner_inc = (r_owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_owner + IDX_W'(1);

`ifdef MOGGYSOC_ARB_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wd_cnt;

  // Zero on the first WAIT cycle, so it equals the number of WAIT cycles
  // already elapsed.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_state != WAIT) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  assign w_timeout = (r_state == WAIT) && (r_wd_cnt == WD_W'(TIMEOUT));
  // A real response arriving in the timeout cycle takes precedence.
  assign m_rsp_err   = w_timeout & ~s_rsp_valid;
  assign m_rsp_rdata = m_rsp_err ? '0 : s_rsp_rdata;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
  assign m_rsp_err        = 1'b0;
  assign m_rsp_rdata      = s_rsp_rdata;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_owner_next  = r_owner;
    w_rr_ptr_next = r_rr_ptr;
    unique case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_owner_next = w_pick_idx;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (s_req_ready) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (w_rsp_fire) begin
          w_rr_ptr_next = w_owner_inc;
          w_state_next  = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_next;
      r_owner  <= w_owner_next;
      r_rr_ptr <= w_rr_ptr_next;
    end
  end

endmodule
